perceptron_train_ctrl: RTL



---
 rtl/perceptron_pkg.sv | 38 +++
 rtl/perceptron_train_ctrl_latency_counter.sv | 34 +++
 rtl/perceptron_train_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the XOR perceptron training controller.
//   state_t    : controller FSM states
//   sample_t   : one training sample (two inputs and a target, IEEE-754 single)
//   XOR_TABLE  : the four XOR samples, indexed by sample number
package perceptron_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned EPOCH_W = 16;
  localparam int unsigned CNT_W   = 8;

  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [DATA_W-1:0] FP_ONE  = 32'h3f80_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FWD_WAIT,
    UPD,
    UPD_WAIT,
    COMMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] t;
  } sample_t;

  localparam sample_t XOR_TABLE [4] = '{
    '{x1: FP_ZERO, x2: FP_ZERO, t: FP_ZERO},
    '{x1: FP_ZERO, x2: FP_ONE,  t: FP_ONE },
    '{x1: FP_ONE,  x2: FP_ZERO, t: FP_ONE },
    '{x1: FP_ONE,  x2: FP_ONE,  t: FP_ZERO}
  };

endpackage

// File: rtl/perceptron_train_ctrl_latency_counter.sv
// Down-counter used to time the forward and update datapath waits.
//   clk, rst_n : clock, async active-low reset
//   load       : capture loadVal (takes priority over dec)
//   dec        : decrement by one; holds at zero, never wraps
//   loadVal    : value to load (latency - 1)
//   zero       : registered flag, high while the count is zero
module latency_counter
  import perceptron_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Zero flag is computed alongside the count so it comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= loadVal;
      zero  <= (loadVal == '0);
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
      zero  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Training sequencer for an XOR perceptron: walks the four samples for
// N_EPOCH epochs, launching forward pass and weight update for each sample
// and pulsing weight load once the update datapath result is valid.
//   iCLK, iRST_N      : clock, async active-low reset
//   iSTART, iSTOP     : start a run (sampled in IDLE), abort from any state
//   oX1, oX2, oT      : current sample inputs and target (IEEE-754 single)
//   oFWD_VALID        : one-cycle forward-pass launch
//   oUPD_VALID        : one-cycle weight-update launch
//   oW_LOAD           : one-cycle weight register capture
//   oSAMPLE_IDX       : current sample 0..3
//   oEPOCH            : current epoch, 0-based
//   oBUSY, oDONE      : not-idle flag, completion pulse
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int unsigned FWD_LATENCY = 8,
  parameter int unsigned UPD_LATENCY = 12,
  parameter int unsigned N_EPOCH     = 1000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iSTART,
  input  logic               iSTOP,
  output logic [DATA_W-1:0]  oX1,
  output logic [DATA_W-1:0]  oX2,
  output logic [DATA_W-1:0]  oT,
  output logic               oFWD_VALID,
  output logic               oUPD_VALID,
  output logic               oW_LOAD,
  output logic [IDX_W-1:0]   oSAMPLE_IDX,
  output logic [EPOCH_W-1:0] oEPOCH,
  output logic               oBUSY,
  output logic               oDONE
);

  // The counter is loaded with latency-1 so the wait state lasts exactly latency cycles.
  localparam logic [CNT_W-1:0]   FWD_LOAD   = CNT_W'(FWD_LATENCY - 1);
  localparam logic [CNT_W-1:0]   UPD_LOAD   = CNT_W'(UPD_LATENCY - 1);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(N_EPOCH - 1);

  state_t             state;
  state_t             nextState;
  logic               cntLoad;
  logic               cntDec;
  logic               cntZero;
  logic [CNT_W-1:0]   cntLoadVal;
  logic [IDX_W-1:0]   nextIdx;
  logic [EPOCH_W-1:0] nextEpoch;
  logic               lastSample;

  latency_counter uWaitCnt (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .load    (cntLoad),
    .dec     (cntDec),
    .loadVal (cntLoadVal),
    .zero    (cntZero)
  );

  // Next-state, wait-counter control and sample/epoch bookkeeping.
  always_comb begin
    nextState  = state;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLoadVal = '0;
    nextIdx    = oSAMPLE_IDX;
    nextEpoch  = oEPOCH;
    lastSample = (oSAMPLE_IDX == IDX_W'(3)) && (oEPOCH == LAST_EPOCH);

    case (state)
      IDLE: begin
        if (iSTART) nextState = LOAD;
      end
      LOAD: begin
        nextState  = FWD_WAIT;
        cntLoad    = 1'b1;
        cntLoadVal = FWD_LOAD;
      end
      FWD_WAIT: begin
        if (cntZero) nextState = UPD;
        else         cntDec    = 1'b1;
      end
      UPD: begin
        nextState  = UPD_WAIT;
        cntLoad    = 1'b1;
        cntLoadVal = UPD_LOAD;
      end
      UPD_WAIT: begin
        if (cntZero) nextState = COMMIT;
        else         cntDec    = 1'b1;
      end
      COMMIT: begin
        nextState = lastSample ? DONE : LOAD;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    // Abort overrides every transition, including start and completion.
    if (iSTOP) nextState = IDLE;

    // Index/epoch only move on entry to LOAD, so the final commit leaves them at their last values.
    if (state == IDLE && nextState == LOAD) begin
      nextIdx   = '0;
      nextEpoch = '0;
    end else if (state == COMMIT && nextState == LOAD) begin
      nextIdx = oSAMPLE_IDX + IDX_W'(1);
      if (oSAMPLE_IDX == IDX_W'(3)) nextEpoch = oEPOCH + EPOCH_W'(1);
    end
  end

  // State register and registered outputs, decoded from the next state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      oX1         <= FP_ZERO;
      oX2         <= FP_ZERO;
      oT          <= FP_ZERO;
      oFWD_VALID  <= 1'b0;
      oUPD_VALID  <= 1'b0;
      oW_LOAD     <= 1'b0;
      oSAMPLE_IDX <= '0;
      oEPOCH      <= '0;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
    end else begin
      state       <= nextState;
      oFWD_VALID  <= (nextState == LOAD);
      oUPD_VALID  <= (nextState == UPD);
      oW_LOAD     <= (nextState == COMMIT);
      oDONE       <= (nextState == DONE);
      oBUSY       <= (nextState != IDLE);
      oSAMPLE_IDX <= nextIdx;
      oEPOCH      <= nextEpoch;
      // Sample operands change only on LOAD entry and hold through COMMIT.
      if (nextState == LOAD) begin
        oX1 <= XOR_TABLE[nextIdx].x1;
        oX2 <= XOR_TABLE[nextIdx].x2;
        oT  <= XOR_TABLE[nextIdx].t;
      end
    end
  end

endmodule
